// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, ROM read latency and the in-flight fetch tag
package fetch_pkg;
  localparam int ADDR_SIZE   = 11;
  localparam int WORD_SIZE   = 9;
  localparam int ROM_LATENCY = 2;
  typedef struct packed {
    logic                 valid;
    logic [ADDR_SIZE-1:0] pc;
  } tag_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: instruction buffer of {pc, word} with synchronous flush
module fetch_fifo #(
  parameter int Width = 20,
  parameter int Depth = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [Width-1:0]       din,
  output logic [Width-1:0]       dout,
  output logic [$clog2(Depth):0] count,
  output logic                   empty,
  output logic                   full
);
  localparam int PW = $clog2(Depth);
  localparam int CW = PW + 1;
  logic [Width-1:0] mem [Depth];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wr_ptr] <= din;
  assign empty = count == '0;
  assign full  = count == CW'(Depth);
  // Empty head reads as zero so stale storage never shows on the outputs
  assign dout  = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, ROM read tracking, instruction buffer and redirect flush
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int AddrSize  = ADDR_SIZE,
  parameter int WordSize  = WORD_SIZE,
  parameter int FifoDepth = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [AddrSize-1:0] rom_addr,
  output logic                rom_en,
  input  logic [WordSize-1:0] rom_do,
  output logic [WordSize-1:0] instr,
  output logic [AddrSize-1:0] instr_pc,
  output logic                instr_valid,
  input  logic                instr_ready,
  input  logic                redirect,
  input  logic [AddrSize-1:0] redirect_pc
);
  localparam int CW = $clog2(FifoDepth) + 1;
  localparam int IW = $clog2(ROM_LATENCY + 1);
  logic [AddrSize-1:0]          pc;
  tag_t                         tags [ROM_LATENCY];
  logic [IW-1:0]                inflight;
  logic [CW-1:0]                count;
  logic                         empty, full, push, pop;
  logic [AddrSize+WordSize-1:0] head;
  always_comb begin
    inflight = '0;
    for (int i = 0; i < ROM_LATENCY; i++) inflight = inflight + IW'(tags[i].valid);
  end
  // Credits count every buffered and in-flight word; same-cycle pops are not credited
  assign rom_en   = rst_n && !redirect && (int'(count) + int'(inflight) < FifoDepth);
  assign push     = tags[ROM_LATENCY-1].valid && !redirect;
  assign pop      = instr_valid && instr_ready && !redirect;
  assign rom_addr = pc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc <= '0;
      for (int i = 0; i < ROM_LATENCY; i++) tags[i] <= '0;
    end else begin
      pc      <= redirect ? redirect_pc : rom_en ? pc + 1'b1 : pc;
      tags[0] <= redirect ? '0 : tag_t'{valid: rom_en, pc: ADDR_SIZE'(pc)};
      for (int i = 1; i < ROM_LATENCY; i++) tags[i] <= redirect ? '0 : tags[i-1];
    end
  fetch_fifo #(.Width(AddrSize + WordSize), .Depth(FifoDepth)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect),
    .push  (push),
    .pop   (pop),
    .din   ({AddrSize'(tags[ROM_LATENCY-1].pc), rom_do}),
    .dout  (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );
  assign instr_valid       = !empty;
  assign {instr_pc, instr} = head;
  no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch ordering, credits, redirect and reset
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] rom_addr;
  logic        rom_en;
  logic [8:0]  rom_do;
  logic [8:0]  instr;
  logic [10:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic        redirect = 1'b0;
  logic [10:0] redirect_pc = '0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        v1 = 1'b0, v2 = 1'b0;
  logic [8:0]  d1 = '0, d2 = '0;

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rom_addr    (rom_addr),
    .rom_en      (rom_en),
    .rom_do      (rom_do),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  always #5 clk = ~clk;

  // ROM with two-cycle registered read, Mem[a] = a[8:0], floating when idle
  always @(posedge clk) begin
    v1 <= rom_en;
    d1 <= rom_addr[8:0];
    v2 <= v1;
    d2 <= d1;
  end
  assign rom_do = v2 ? d2 : 'z;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_instr(input string tag, input logic [10:0] pc);
    check({tag, "_valid"}, 32'(instr_valid), 32'd1);
    check({tag, "_pc"}, 32'(instr_pc), 32'(pc));
    check({tag, "_instr"}, 32'(instr), 32'(pc[8:0]));
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
  endtask

  // Redirect in the current cycle r, then follow the new stream through r+4 onward
  task automatic do_redirect(input string tag, input logic [10:0] target, input int n_out);
    logic [10:0] p;
    redirect = 1'b1;
    redirect_pc = target;
    #1;
    check({tag, "_no_issue"}, 32'(rom_en), 32'd0);
    step();
    redirect = 1'b0;
    #1;
    expect_idle({tag, "_r1"});
    check({tag, "_r1_en"}, 32'(rom_en), 32'd1);
    check({tag, "_r1_addr"}, 32'(rom_addr), 32'(target));
    step();
    expect_idle({tag, "_r2"});
    p = target + 11'd1;
    check({tag, "_r2_addr"}, 32'(rom_addr), 32'(p));
    step();
    expect_idle({tag, "_r3"});
    p = target;
    for (int k = 0; k < n_out; k++) begin
      step();
      expect_instr($sformatf("%s_out%0d", tag, k), p);
      p = p + 11'd1;
    end
  endtask

  always @(negedge clk)
    if (rst_n) check("fifo_overflow", 32'(dut.push && dut.u_fifo.full), 32'd0);

  initial begin
    repeat (3) step();
    check("rst_rom_en", 32'(rom_en), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_instr_pc", 32'(instr_pc), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);

    rst_n = 1'b1;
    #1;
    check("c0_en", 32'(rom_en), 32'd1);
    check("c0_addr", 32'(rom_addr), 32'd0);
    step();
    expect_idle("c1");
    check("c1_addr", 32'(rom_addr), 32'd1);
    step();
    expect_idle("c2");
    step();
    expect_instr("stream0", 11'd0);
    for (int k = 1; k <= 20; k++) begin
      step();
      expect_instr($sformatf("stream%0d", k), 11'(k));
      check($sformatf("stream%0d_en", k), 32'(rom_en), 32'd1);
    end

    do_redirect("redir100", 11'h100, 3);
    do_redirect("redir7fe", 11'h7FE, 4);

    // Stall one cycle so the FIFO holds two words with two reads in flight, then reset mid-cycle
    instr_ready = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("arst_en", 32'(rom_en), 32'd0);
    check("arst_addr", 32'(rom_addr), 32'd0);
    check("arst_instr", 32'(instr), 32'd0);
    check("arst_instr_pc", 32'(instr_pc), 32'd0);
    check("arst_valid", 32'(instr_valid), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_c0_en", 32'(rom_en), 32'd1);
    check("rel_c0_addr", 32'(rom_addr), 32'd0);
    for (int c = 1; c <= 3; c++) begin
      step();
      check($sformatf("rel_c%0d_en", c), 32'(rom_en), 32'd1);
      check($sformatf("rel_c%0d_addr", c), 32'(rom_addr), 32'(c));
      if (c < 3) expect_idle($sformatf("rel_c%0d", c));
    end
    expect_instr("rel_c3", 11'd0);
    for (int c = 4; c <= 7; c++) begin
      step();
      check($sformatf("stall_c%0d_en", c), 32'(rom_en), 32'd0);
      expect_instr($sformatf("stall_c%0d", c), 11'd0);
    end
    step();
    instr_ready = 1'b1;
    #1;
    expect_instr("resume0", 11'd0);
    check("resume0_en", 32'(rom_en), 32'd0);
    step();
    expect_instr("resume1", 11'd1);
    check("resume1_en", 32'(rom_en), 32'd1);
    check("resume1_addr", 32'(rom_addr), 32'd4);
    for (int k = 2; k <= 12; k++) begin
      step();
      expect_instr($sformatf("resume%0d", k), 11'(k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
